// File: rtl/if_fetch_queue.sv
// Fetch-to-decode decoupling queue.
// Buffers {exc, pc, instr} so a decode stall does not stall the PC register.
// Fetch stalls only on a full queue. A flush drops every wrong-path entry.
// The exc tag flags a misaligned or out-of-range fetch address. It is
// computed when the entry is enqueued and travels with the entry.
module if_fetch_queue #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] PC_LO = 32'h0000_3000,
  parameter logic [31:0] PC_HI = 32'h0000_6ffc
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_exc,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef struct packed {
    logic        exc;
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;

  logic             push;
  logic             pop;
  logic             in_exc;
  entry_t           head;
  logic [PW-1:0]    rd_ptr_nxt;
  logic [PW-1:0]    wr_ptr_nxt;
  logic [CW-1:0]    count_nxt;

  // Handshakes and fault tag from current-cycle signals; in_ready never looks at out_ready.
  always_comb begin
    in_ready  = (count_q != FULL_CNT);
    out_valid = (count_q != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    in_exc    = (in_pc[1:0] != 2'b00) | (in_pc < PC_LO) | (in_pc > PC_HI);
  end

  // Next pointer/occupancy values. The flush check only covers the flush cycle.
  // Reset is handled in the register block below.
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count_q;
    if (flush) begin
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + PTR_ONE;
      if (pop)  rd_ptr_nxt = rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count_nxt = count_q + CNT_ONE;
        2'b01:   count_nxt = count_q - CNT_ONE;
        default: count_nxt = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      rd_ptr  <= rd_ptr_nxt;
      wr_ptr  <= wr_ptr_nxt;
      count_q <= count_nxt;
    end
  end

  // Entry storage. Contents are don't-care until written, so there is no reset.
  // A push in a flush or reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset && !flush && push) begin
      mem[wr_ptr] <= '{exc: in_exc, pc: in_pc, instr: in_instr};
    end
  end

  // Head presentation. Fields are zeroed while empty so stale entries never leak out.
  always_comb begin
    head      = mem[rd_ptr];
    out_pc    = '0;
    out_instr = '0;
    out_exc   = 1'b0;
    if (out_valid) begin
      out_pc    = head.pc;
      out_instr = head.instr;
      out_exc   = head.exc;
    end
  end

  assign count = count_q;

endmodule
